coriolis_ker0_stream_seq: RTL and testbench

//  Sequencer for the coriolis ker0 kernel datapath. After start, reads NELEM (u,v) pairs from two

---
 rtl/coriolis_ker0_stream_seq_pkg.sv | 13 +
 rtl/coriolis_ker0_seq_fifo.sv | 52 +++++
 rtl/coriolis_ker0_stream_seq.sv | 138 +++++++++++++
 tb/tb_coriolis_ker0_stream_seq.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/coriolis_ker0_stream_seq_pkg.sv
// Shared definitions for the coriolis ker0 stream sequencer: FSM states and default word width.
package coriolis_ker0_stream_seq_pkg;

    localparam int STREAMW_DEF = 34;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/coriolis_ker0_seq_fifo.sv
// Synchronous FIFO feeding the kernel; the head word is presented combinationally (show-ahead).
module coriolis_ker0_seq_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is still legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only, so it is not reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/coriolis_ker0_stream_seq.sv
// Job sequencer: reads (u,v) pairs, feeds the ker0 kernel through a credit-limited FIFO,
// writes (un,vn) results to output memory and pulses done at the end of the job.
module coriolis_ker0_stream_seq
    import coriolis_ker0_stream_seq_pkg::*;
#(
    parameter int STREAMW = STREAMW_DEF,
    parameter int ADDRW   = 16,
    parameter int RDLAT   = 2,
    parameter int FIFOD   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDRW-1:0]   nelem,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [ADDRW-1:0]   rd_addr,
    input  logic [STREAMW-1:0] rd_u,
    input  logic [STREAMW-1:0] rd_v,
    output logic               k_ivalid,
    output logic [STREAMW-1:0] k_u,
    output logic [STREAMW-1:0] k_v,
    input  logic               k_iready,
    input  logic               k_ovalid,
    input  logic [STREAMW-1:0] k_un,
    input  logic [STREAMW-1:0] k_vn,
    output logic               k_oready,
    output logic               wr_en,
    output logic [ADDRW-1:0]   wr_addr,
    output logic [STREAMW-1:0] wr_un,
    output logic [STREAMW-1:0] wr_vn,
    input  logic               wr_ready
);
    // One extra bit keeps nelem = 2^ADDRW-1 from wrapping in the count compares.
    localparam int CNTW = ADDRW + 1;
    localparam int FCW  = $clog2(FIFOD) + 1;
    localparam int CRW  = $clog2(FIFOD + RDLAT + 1) + 1;

    state_t               state;
    state_t               state_nxt;
    logic [CNTW-1:0]      nelem_q;
    logic [CNTW-1:0]      issued;
    logic [CNTW-1:0]      written;
    logic [CNTW-1:0]      written_nxt;
    logic [RDLAT-1:0]     vld_p;
    logic [CRW-1:0]       inflight;
    logic [CRW-1:0]       credit_used;
    logic [FCW-1:0]       fifo_cnt;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 push;
    logic                 pop;
    logic                 accept;
    logic [2*STREAMW-1:0] fifo_head;

    assign accept      = start && (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign written_nxt = written + CNTW'(wr_en);

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RDLAT; i++) inflight = inflight + CRW'(vld_p[i]);
    end

    assign credit_used = inflight + CRW'(fifo_cnt);
    assign rd_en       = (state == ST_RUN) && (issued < nelem_q) && (credit_used < CRW'(FIFOD));
    assign rd_addr     = issued[ADDRW-1:0];

    assign push     = vld_p[RDLAT-1];
    assign k_ivalid = !fifo_empty;
    assign pop      = k_ivalid && k_iready;
    assign k_u      = fifo_head[2*STREAMW-1:STREAMW];
    assign k_v      = fifo_head[STREAMW-1:0];

    assign k_oready = wr_ready && busy;
    assign wr_en    = k_ovalid && k_oready;
    assign wr_addr  = written[ADDRW-1:0];
    assign wr_un    = k_un;
    assign wr_vn    = k_vn;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Leaving DRAIN on the final write lets done coincide with the cycle after that write.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = (nelem == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (issued == nelem_q) state_nxt = ST_DRAIN;
            ST_DRAIN: if (written_nxt == nelem_q) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nelem_q <= '0;
            issued  <= '0;
            written <= '0;
            vld_p   <= '0;
        end else begin
            vld_p <= (vld_p << 1) | RDLAT'(rd_en);
            if (accept) begin
                nelem_q <= {1'b0, nelem};
                issued  <= '0;
                written <= '0;
            end else begin
                if (rd_en) issued <= issued + CNTW'(1);
                written <= written_nxt;
            end
        end
    end

    coriolis_ker0_seq_fifo #(
        .WIDTH (2*STREAMW),
        .DEPTH (FIFOD)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({rd_u, rd_v}),
        .pop   (pop),
        .head  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_cnt)
    );

    // The credit rule must make an unabsorbed push into a full FIFO impossible.
    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_coriolis_ker0_stream_seq.sv
// Bench for coriolis_ker0_stream_seq: behavioural memory/kernel models plus count-based reference.
module tb_coriolis_ker0_stream_seq;
    localparam int STREAMW = 34;
    localparam int ADDRW   = 16;
    localparam int RDLAT   = 2;
    localparam int FIFOD   = 4;
    localparam int KCAP    = 2;
    localparam int MAXN    = 64;

    typedef logic [STREAMW-1:0] word_t;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [ADDRW-1:0]   nelem = '0;
    logic               busy, done, rd_en, k_ivalid, k_oready, wr_en;
    logic [ADDRW-1:0]   rd_addr, wr_addr;
    logic [STREAMW-1:0] k_u, k_v, wr_un, wr_vn;
    logic [STREAMW-1:0] rd_u = '0, rd_v = '0, k_un = '0, k_vn = '0;
    logic               k_iready = 1'b0, k_ovalid = 1'b0, wr_ready = 1'b0;

    coriolis_ker0_stream_seq #(
        .STREAMW(STREAMW), .ADDRW(ADDRW), .RDLAT(RDLAT), .FIFOD(FIFOD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .nelem(nelem), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_u(rd_u), .rd_v(rd_v),
        .k_ivalid(k_ivalid), .k_u(k_u), .k_v(k_v), .k_iready(k_iready),
        .k_ovalid(k_ovalid), .k_un(k_un), .k_vn(k_vn), .k_oready(k_oready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_un(wr_un), .wr_vn(wr_vn), .wr_ready(wr_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: element counts per job, not the DUT's internal registers.
    word_t mu [MAXN];
    word_t mv [MAXN];
    int    issue_cyc [MAXN];
    word_t kq_un [$];
    word_t kq_vn [$];
    int    rdq [$];
    int    gcyc = 0, start_cyc = 0, done_cyc = -1;
    int    n_job = 0, issued = 0, popped = 0, wcount = 0;
    bit    active = 1'b0;

    int    first_rd_rel, first_kiv_rel, done_rel, done_pulses, writes, reads;
    word_t first_un, first_vn;

    function automatic word_t f_un(input word_t u, input word_t v);
        return u + v;
    endfunction

    function automatic word_t f_vn(input word_t u, input word_t v);
        return u - v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, gcyc);
        end
    endtask

    task automatic model_clear();
        kq_un.delete();
        kq_vn.delete();
        rdq.delete();
        for (int i = 0; i < RDLAT; i++) rdq.push_back(-1);
        active = 1'b0; issued = 0; popped = 0; wcount = 0; done_cyc = -1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_k_ivalid"}, k_ivalid, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
    endtask

    // One clock cycle: drive inputs at negedge, check outputs, then advance the models.
    task automatic step(input bit st, input bit ext_ir, input bit wrr);
        bit exp_rd, exp_kiv, exp_wr;
        int rel;
        @(negedge clk);
        start    = st;
        k_iready = ext_ir && (kq_un.size() < KCAP);
        k_ovalid = (kq_un.size() > 0);
        k_un     = k_ovalid ? kq_un[0] : '0;
        k_vn     = k_ovalid ? kq_vn[0] : '0;
        wr_ready = wrr;
        rd_u     = (rdq[0] >= 0) ? mu[rdq[0]] : word_t'({$urandom, $urandom});
        rd_v     = (rdq[0] >= 0) ? mv[rdq[0]] : word_t'({$urandom, $urandom});
        #1;
        rel     = gcyc - start_cyc;
        exp_rd  = active && (issued < n_job) && ((issued - popped) < FIFOD);
        exp_kiv = (popped < issued) && (issue_cyc[popped] + RDLAT + 1 <= gcyc);
        exp_wr  = k_ovalid && wrr && active;
        chk("busy", busy, active);
        chk("done", done, gcyc == done_cyc);
        chk("rd_en", rd_en, exp_rd);
        chk("rd_addr", rd_addr, ADDRW'(issued));
        chk("k_ivalid", k_ivalid, exp_kiv);
        if (exp_kiv) begin
            chk("k_u", k_u, mu[popped]);
            chk("k_v", k_v, mv[popped]);
        end
        chk("wr_en", wr_en, exp_wr);
        chk("wr_addr", wr_addr, ADDRW'(wcount));
        if (exp_wr && wcount < n_job) begin
            chk("wr_un", wr_un, f_un(mu[wcount], mv[wcount]));
            chk("wr_vn", wr_vn, f_vn(mu[wcount], mv[wcount]));
        end

        if (rd_en) begin
            reads++;
            if (first_rd_rel < 0) first_rd_rel = rel;
        end
        if (k_ivalid && first_kiv_rel < 0) first_kiv_rel = rel;
        if (wr_en) begin
            if (writes == 0) begin first_un = wr_un; first_vn = wr_vn; end
            writes++;
        end
        if (done) begin done_pulses++; done_rel = rel; end

        void'(rdq.pop_front());
        rdq.push_back(rd_en ? int'(rd_addr) : -1);
        if (exp_rd) begin issue_cyc[issued] = gcyc; issued++; end
        if (k_ivalid && k_iready) begin
            kq_un.push_back(f_un(k_u, k_v));
            kq_vn.push_back(f_vn(k_u, k_v));
        end
        if (exp_kiv && k_iready) popped++;
        if (k_ovalid && k_oready) begin
            void'(kq_un.pop_front());
            void'(kq_vn.pop_front());
        end
        if (exp_wr && wcount < n_job) begin
            if (wcount + 1 == n_job) done_cyc = gcyc + 1;
            wcount++;
        end
        if (active && gcyc == done_cyc) begin
            active = 1'b0;
        end else if (st && !active) begin
            active = 1'b1; issued = 0; popped = 0; wcount = 0;
            n_job = int'(nelem);
            if (n_job == 0) done_cyc = gcyc + 1;
        end
        gcyc++;
    endtask

    task automatic do_reset_mid();
        @(negedge clk);
        #2 rst = 1'b0;
        start = 1'b0;
        #1 chk_reset_outputs("midrst");
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        gcyc += 3;
    endtask

    // mode 0: all ready; 1: kernel stalled rel 5..14; 2: wr_ready toggles every 3; 3: random.
    task automatic run_job(input int n, input int mode, input int restart_at, input int rst_at,
                           input bit pin_first);
        int  rel;
        bit  ir, wrr, finished;
        start_cyc = gcyc;
        first_rd_rel = -1; first_kiv_rel = -1; done_rel = -1;
        done_pulses = 0; writes = 0; reads = 0;
        nelem = ADDRW'(n);
        for (int i = 0; i < n; i++) begin
            mu[i] = word_t'({$urandom, $urandom});
            mv[i] = word_t'({$urandom, $urandom});
        end
        if (pin_first) begin mu[0] = '1; mv[0] = word_t'(1); end
        rel = 0;
        finished = 1'b0;
        while (!finished) begin
            if (rel == rst_at) begin
                do_reset_mid();
                return;
            end
            ir = 1'b1;
            wrr = 1'b1;
            case (mode)
                1: ir = !(rel >= 5 && rel <= 14);
                2: wrr = ((rel / 3) % 2) == 0;
                3: begin ir = ($urandom_range(0, 3) != 0); wrr = ($urandom_range(0, 3) != 0); end
                default: ;
            endcase
            step((rel == 0) || (rel == restart_at), ir, wrr);
            rel++;
            if (rel > 1 && !active) begin
                finished = 1'b1;
            end else if (rel > 600) begin
                checks++;
                errors++;
                $display("FAIL job_timeout: n=%0d still busy after %0d cycles", n, rel);
                finished = 1'b1;
            end
        end
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b1;
        step(1'b0, 1'b1, 1'b1);

        // Basic streaming job with hand-derived timing and a pinned first result.
        run_job(8, 0, -1, -1, 1'b1);
        chk("t1_first_rd_cycle", first_rd_rel, 1);
        chk("t1_first_kivalid_cycle", first_kiv_rel, 2 + RDLAT);
        chk("t1_done_cycle", done_rel, 13);
        chk("t1_done_pulses", done_pulses, 1);
        chk("t1_reads", reads, 8);
        chk("t1_writes", writes, 8);
        chk("t1_first_un", first_un, 34'h0);
        chk("t1_first_vn", first_vn, 34'h3_FFFF_FFFE);

        run_job(0, 0, -1, -1, 1'b0);
        chk("t2_done_pulses", done_pulses, 1);
        chk("t2_done_cycle", done_rel, 1);
        chk("t2_reads", reads, 0);
        chk("t2_writes", writes, 0);

        run_job(16, 1, -1, -1, 1'b0);
        chk("t3_writes", writes, 16);
        chk("t3_done_pulses", done_pulses, 1);

        run_job(10, 2, -1, -1, 1'b0);
        chk("t4_writes", writes, 10);
        chk("t4_done_pulses", done_pulses, 1);

        run_job(8, 0, 4, -1, 1'b0);
        chk("t5_writes", writes, 8);
        chk("t5_done_pulses", done_pulses, 1);

        run_job(20, 0, -1, 6, 1'b0);
        chk("t6_no_done_before_reset", done_pulses, 0);
        run_job(3, 0, -1, -1, 1'b0);
        chk("t6_writes_after_reset", writes, 3);
        chk("t6_done_pulses", done_pulses, 1);

        // A stray kernel result while idle must not be written.
        kq_un.push_back(word_t'(5));
        kq_vn.push_back(word_t'(6));
        step(1'b0, 1'b1, 1'b1);
        chk("idle_k_oready", k_oready, 0);
        kq_un.delete();
        kq_vn.delete();

        for (int j = 0; j < 4; j++) begin
            int n;
            n = int'($urandom_range(1, 40));
            run_job(n, 3, -1, -1, 1'b0);
            chk("rand_writes", writes, n);
            chk("rand_done_pulses", done_pulses, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
